// File: rtl/fetch_miss_refill_if.sv
// Beat-wise memory read bus between the miss refill engine (master)
// and the memory side (slave).
interface fetch_miss_refill_if #(
    parameter int memBusWidth = 64
);
    logic                   memReqValid_o;
    logic                   memReqReady_i;
    logic [63:0]            memReqAddr_o;
    logic                   memRspValid_i;
    logic [memBusWidth-1:0] memRspData_i;

    modport master (
        output memReqValid_o,
        output memReqAddr_o,
        input  memReqReady_i,
        input  memRspValid_i,
        input  memRspData_i
    );

    modport slave (
        input  memReqValid_o,
        input  memReqAddr_o,
        output memReqReady_i,
        output memRspValid_i,
        output memRspData_i
    );
endinterface

// File: rtl/fetch_miss_refill.sv
// Fetch miss refill: queues misses, reads lines beat-wise, writes cache.
// Optional MISS_DEDUP_EN drops misses to lines already queued/in flight.
module fetch_miss_refill #(
    parameter int offsetSize        = 5,
    parameter int indexSize         = 8,
    parameter int tagSize           = 64 - (offsetSize + indexSize),
    parameter int cachelineSizeBits = (2 ** offsetSize) * 8,
    parameter int memBusWidth       = 64,
    parameter int queueDepth        = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [tagSize-1:0]           missTag_i,
    input  logic [indexSize-1:0]         missIndex_i,
    input  logic [offsetSize-1:0]        missOffset_i,
    input  logic                         isCacheMiss_i,
    output logic                         missQueueFull_o,
    output logic                         missOverflow_o,
    fetch_miss_refill_if.master          mem,
    output logic [tagSize-1:0]           newTag_o,
    output logic [indexSize-1:0]         newIndex_o,
    output logic [offsetSize-1:0]        newOffset_o,
    output logic [cachelineSizeBits-1:0] newCacheline_o,
    output logic                         cacheUpdateEnable_o
);

    localparam int beatsPerLine = cachelineSizeBits / memBusWidth;
    localparam int BW = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;
    localparam int PW = (queueDepth > 1) ? $clog2(queueDepth) : 1;
    localparam int CW = $clog2(queueDepth + 1);

    typedef struct packed {
        logic [tagSize-1:0]    tag;
        logic [indexSize-1:0]  index;
        logic [offsetSize-1:0] offset;
    } miss_t;

    typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

    state_t                 state_q, state_d;
    miss_t                  fifo_q [queueDepth];
    miss_t                  miss_in, cur_q;
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic                   full, empty, pop, accept, dup;
    logic                   overflow_q;
    logic                   req_valid, capture, upd, last_beat;
    logic [BW-1:0]          beat_q;
    logic [cachelineSizeBits-1:0] line_q, line_d, new_line_q;
    logic [tagSize-1:0]     new_tag_q;
    logic [indexSize-1:0]   new_index_q;
    logic [offsetSize-1:0]  new_offset_q;

    assign miss_in   = {missTag_i, missIndex_i, missOffset_i};
    assign full      = (count == CW'(queueDepth));
    assign empty     = (count == '0);
    assign pop       = (state_q == IDLE) && !empty;
    assign accept    = isCacheMiss_i && !dup && (!full || pop);
    assign last_beat = (beat_q == BW'(beatsPerLine - 1));

`ifdef MISS_DEDUP_EN
    logic [PW-1:0] rel;

    // Only slots between rd_ptr and rd_ptr+count hold live entries.
    always_comb begin
        dup = 1'b0;
        rel = '0;
        for (int i = 0; i < queueDepth; i++) begin
            rel = PW'(i) - rd_ptr;
            if ((CW'(rel) < count) &&
                (fifo_q[i].tag == missTag_i) &&
                (fifo_q[i].index == missIndex_i))
                dup = 1'b1;
        end
        if ((state_q != IDLE) &&
            (cur_q.tag == missTag_i) &&
            (cur_q.index == missIndex_i))
            dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (pop && !accept)
                count <= count - CW'(1);
            if (isCacheMiss_i && !dup && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept)
            fifo_q[wr_ptr] <= miss_in;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        capture   = 1'b0;
        upd       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty)
                    state_d = REQ;
            end
            REQ: begin
                req_valid = 1'b1;
                if (mem.memReqReady_i)
                    state_d = RECV;
            end
            RECV: begin
                capture = mem.memRspValid_i;
                if (mem.memRspValid_i && last_beat)
                    state_d = WRITE;
            end
            WRITE: begin
                upd     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_d = line_q;
        for (int k = 0; k < beatsPerLine; k++) begin
            if (capture && (beat_q == BW'(k)))
                line_d[k*memBusWidth +: memBusWidth] = mem.memRspData_i;
        end
    end

    // Update outputs load at the last beat so they hold after the strobe.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cur_q        <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            new_line_q   <= '0;
            new_tag_q    <= '0;
            new_index_q  <= '0;
            new_offset_q <= '0;
        end else begin
            if (pop)
                cur_q <= fifo_q[rd_ptr];
            if ((state_q == REQ) && mem.memReqReady_i)
                beat_q <= '0;
            else if (capture)
                beat_q <= beat_q + BW'(1);
            if (capture)
                line_q <= line_d;
            if (capture && last_beat) begin
                new_line_q   <= line_d;
                new_tag_q    <= cur_q.tag;
                new_index_q  <= cur_q.index;
                new_offset_q <= cur_q.offset;
            end
        end
    end

    assign missQueueFull_o     = full;
    assign missOverflow_o      = overflow_q;
    assign mem.memReqValid_o   = req_valid;
    assign mem.memReqAddr_o    = {cur_q.tag, cur_q.index, {offsetSize{1'b0}}};
    assign newTag_o            = new_tag_q;
    assign newIndex_o          = new_index_q;
    assign newOffset_o         = new_offset_q;
    assign newCacheline_o      = new_line_q;
    assign cacheUpdateEnable_o = upd;

endmodule

// File: tb/tb_fetch_miss_refill.sv
// Directed bench for fetch_miss_refill: latency, stall, overflow,
// full push/pop, mid-transfer reset and duplicate misses.
module tb_fetch_miss_refill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [50:0]  miss_tag;
    logic [7:0]   miss_index;
    logic [4:0]   miss_offset;
    logic         miss_v;
    logic         q_full, ovf, upd;
    logic [50:0]  new_tag;
    logic [7:0]   new_index;
    logic [4:0]   new_offset;
    logic [255:0] new_line;

    int errors = 0;
    int checks = 0;

`ifdef MISS_DEDUP_EN
    localparam int DUP_EXP = 1;
`else
    localparam int DUP_EXP = 2;
`endif

    always #5 clk = ~clk;

    fetch_miss_refill_if #(.memBusWidth(64)) m ();

    fetch_miss_refill dut (
        .clock_i            (clk),
        .reset_i            (rst_n),
        .missTag_i          (miss_tag),
        .missIndex_i        (miss_index),
        .missOffset_i       (miss_offset),
        .isCacheMiss_i      (miss_v),
        .missQueueFull_o    (q_full),
        .missOverflow_o     (ovf),
        .mem                (m.master),
        .newTag_o           (new_tag),
        .newIndex_o         (new_index),
        .newOffset_o        (new_offset),
        .newCacheline_o     (new_line),
        .cacheUpdateEnable_o(upd)
    );

    function automatic logic [63:0] beat_val(input int k,
                                             input logic [63:0] seed);
        logic [63:0] mul;
        mul = 64'(k + 1);
        return (64'h1111_1111_1111_1111 * mul) ^ seed;
    endfunction

    function automatic logic [255:0] line_val(input logic [63:0] seed);
        return {beat_val(3, seed), beat_val(2, seed),
                beat_val(1, seed), beat_val(0, seed)};
    endfunction

    function automatic logic [63:0] addr_of(input logic [50:0] t,
                                            input logic [7:0] i);
        return {t, i, 5'b0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        miss_v = 1'b0;
        miss_tag = '0;
        miss_index = '0;
        miss_offset = '0;
        m.memReqReady_i = 1'b0;
        m.memRspValid_i = 1'b0;
        m.memRspData_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_miss(input logic [50:0] t, input logic [7:0] i,
                             input logic [4:0] o);
        miss_tag = t;
        miss_index = i;
        miss_offset = o;
        miss_v = 1'b1;
        @(negedge clk);
        miss_v = 1'b0;
    endtask

    task automatic wait_req(output logic ok);
        int n;
        n = 0;
        while (!m.memReqValid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = m.memReqValid_o;
    endtask

    task automatic handshake();
        m.memReqReady_i = 1'b1;
        @(negedge clk);
        m.memReqReady_i = 1'b0;
    endtask

    task automatic beats(input logic [63:0] seed);
        for (int k = 0; k < 4; k++) begin
            m.memRspValid_i = 1'b1;
            m.memRspData_i = beat_val(k, seed);
            @(negedge clk);
        end
        m.memRspValid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        miss_v = 1'b0;
        m.memReqReady_i = 1'b0;
        m.memRspValid_i = 1'b0;
        m.memRspData_i = '0;
        @(negedge clk);
        checks++;
        if (q_full !== 1'b0) begin
            errors++; $display("FAIL rst_full got %b want 0", q_full);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL rst_ovf got %b want 0", ovf);
        end
        checks++;
        if (m.memReqValid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b want 0", m.memReqValid_o);
        end
        checks++;
        if (m.memReqAddr_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_addr got %h want 0", m.memReqAddr_o);
        end
        checks++;
        if (upd !== 1'b0 || new_line !== '0 || new_tag !== '0) begin
            errors++;
            $display("FAIL rst_upd got %b/%h want 0/0", upd, new_line);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [255:0] exp_line;
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        send_miss(51'h1, 8'h05, 5'h0C);
        checks++;
        if (m.memReqValid_o !== 1'b0) begin
            errors++; $display("FAIL lat_early got 1 want 0");
        end
        @(negedge clk);
        checks++;
        if (m.memReqValid_o !== 1'b1) begin
            errors++; $display("FAIL lat_req got 0 want 1");
        end
        checks++;
        if (m.memReqAddr_o !== 64'h0000_0000_0000_20A0) begin
            errors++;
            $display("FAIL single_addr got %h want 20a0", m.memReqAddr_o);
        end
        handshake();
        beats(64'h0);
        checks++;
        if (upd !== 1'b1) begin
            errors++; $display("FAIL single_upd got %b want 1", upd);
        end
        checks++;
        if (new_line !== exp_line) begin
            errors++;
            $display("FAIL single_line got %h want %h", new_line, exp_line);
        end
        checks++;
        if (new_offset !== 5'h0C || new_tag !== 51'h1 ||
            new_index !== 8'h05) begin
            errors++;
            $display("FAIL single_tio got %h/%h/%h want 1/05/0c",
                     new_tag, new_index, new_offset);
        end
        @(negedge clk);
        checks++;
        if (upd !== 1'b0 || new_line !== exp_line) begin
            errors++;
            $display("FAIL single_hold got %b/%h want 0/%h",
                     upd, new_line, exp_line);
        end
    endtask

    task automatic test_stall();
        logic ok;
        send_miss(51'h2, 8'h07, 5'h03);
        wait_req(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL stall_req got %b want 1", ok);
        end
        for (int c = 0; c < 10; c++) begin
            m.memRspValid_i = 1'b1;
            m.memRspData_i = 64'hDEAD_BEEF_0000_0000 | 64'(c);
            @(negedge clk);
            checks++;
            if (m.memReqValid_o !== 1'b1 || upd !== 1'b0 ||
                m.memReqAddr_o !== 64'h40E0) begin
                errors++;
                $display("FAIL stall_hold c=%0d got %b/%h want 1/40e0",
                         c, m.memReqValid_o, m.memReqAddr_o);
            end
        end
        m.memRspValid_i = 1'b0;
        handshake();
        beats(64'h5A5A_5A5A_5A5A_5A5A);
        checks++;
        if (upd !== 1'b1 || new_line !== line_val(64'h5A5A_5A5A_5A5A_5A5A))
        begin
            errors++;
            $display("FAIL stall_line got %b/%h", upd, new_line);
        end
    endtask

    task automatic test_overflow();
        logic ok;
        logic [50:0] et;
        do_reset();
        send_miss(51'h100, 8'h10, 5'h0);
        wait_req(ok);
        for (int i = 0; i < 5; i++) begin
            miss_tag = 51'h20 + 51'(i);
            miss_index = 8'h30 + 8'(i);
            miss_offset = 5'(i);
            miss_v = 1'b1;
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (q_full !== (i >= 3) || ovf !== (i == 4)) begin
                    errors++;
                    $display("FAIL ovf_fill i=%0d got full=%b ovf=%b",
                             i, q_full, ovf);
                end
            end
        end
        miss_v = 1'b0;
        handshake();
        beats(64'h0);
        checks++;
        if (upd !== 1'b1 || new_tag !== 51'h100) begin
            errors++;
            $display("FAIL ovf_block got %b/%h want 1/100", upd, new_tag);
        end
        for (int j = 0; j < 4; j++) begin
            et = 51'h20 + 51'(j);
            wait_req(ok);
            checks++;
            if (ok !== 1'b1 ||
                m.memReqAddr_o !== addr_of(et, 8'h30 + 8'(j))) begin
                errors++;
                $display("FAIL ovf_order j=%0d got %b/%h want 1/%h", j, ok,
                         m.memReqAddr_o, addr_of(et, 8'h30 + 8'(j)));
            end
            handshake();
            beats(64'(j));
            checks++;
            if (upd !== 1'b1 || new_tag !== et || new_offset !== 5'(j) ||
                new_line !== line_val(64'(j))) begin
                errors++;
                $display("FAIL ovf_upd j=%0d got %b/%h want 1/%h",
                         j, upd, new_tag, et);
            end
        end
        wait_req(ok);
        checks++;
        if (ok !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fifth got req=%b ovf=%b want 0/1", ok, ovf);
        end
    endtask

    task automatic test_push_pop_full();
        logic ok;
        logic [50:0] et;
        logic [7:0]  ei;
        do_reset();
        send_miss(51'h200, 8'h01, 5'h0);
        wait_req(ok);
        for (int i = 0; i < 4; i++) begin
            miss_tag = 51'h300 + 51'(i);
            miss_index = 8'(i);
            miss_offset = 5'h0;
            miss_v = 1'b1;
            @(negedge clk);
        end
        miss_v = 1'b0;
        handshake();
        beats(64'h0);
        @(negedge clk);
        checks++;
        if (q_full !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL pp_pre got full=%b ovf=%b want 1/0", q_full, ovf);
        end
        send_miss(51'h3FF, 8'hFF, 5'h1);
        checks++;
        if (q_full !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL pp_post got full=%b ovf=%b want 1/0", q_full, ovf);
        end
        for (int j = 0; j < 5; j++) begin
            et = (j < 4) ? 51'h300 + 51'(j) : 51'h3FF;
            ei = (j < 4) ? 8'(j) : 8'hFF;
            wait_req(ok);
            checks++;
            if (ok !== 1'b1 || m.memReqAddr_o !== addr_of(et, ei)) begin
                errors++;
                $display("FAIL pp_order j=%0d got %b/%h want 1/%h",
                         j, ok, m.memReqAddr_o, addr_of(et, ei));
            end
            handshake();
            beats(64'h0);
        end
        checks++;
        if (ovf !== 1'b0 || new_tag !== 51'h3FF || new_offset !== 5'h1) begin
            errors++;
            $display("FAIL pp_last got ovf=%b tag=%h want 0/3ff", ovf, new_tag);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   seen;
        send_miss(51'h7, 8'h09, 5'h2);
        wait_req(ok);
        handshake();
        for (int k = 0; k < 2; k++) begin
            m.memRspValid_i = 1'b1;
            m.memRspData_i = beat_val(k, 64'hF0F0);
            @(negedge clk);
        end
        m.memRspValid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (upd !== 1'b0 || m.memReqValid_o !== 1'b0 ||
            new_line !== '0 || new_tag !== '0 || new_offset !== '0 ||
            m.memReqAddr_o !== '0 || q_full !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got upd=%b line=%h tag=%h want all 0",
                     upd, new_line, new_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            m.memRspValid_i = (c < 2);
            m.memRspData_i = beat_val(c + 2, 64'hF0F0);
            @(negedge clk);
            if (upd === 1'b1 || m.memReqValid_o === 1'b1) seen++;
        end
        m.memRspValid_i = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_quiet got %0d want 0", seen);
        end
        send_miss(51'h8, 8'h0A, 5'h4);
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || m.memReqAddr_o !== addr_of(51'h8, 8'h0A)) begin
            errors++;
            $display("FAIL mid_req got %b/%h want 1/%h", ok, m.memReqAddr_o,
                     addr_of(51'h8, 8'h0A));
        end
        handshake();
        beats(64'h77);
        checks++;
        if (upd !== 1'b1 || new_line !== line_val(64'h77) ||
            new_tag !== 51'h8) begin
            errors++;
            $display("FAIL mid_refill got %b/%h", upd, new_line);
        end
    endtask

    task automatic test_dedup();
        logic ok;
        int   reqs;
        int   strobes;
        do_reset();
        send_miss(51'h55, 8'h22, 5'h1);
        @(negedge clk);
        send_miss(51'h55, 8'h22, 5'h1);
        reqs = 0;
        strobes = 0;
        for (int r = 0; r < 3; r++) begin
            wait_req(ok);
            if (ok) begin
                reqs++;
                handshake();
                beats(64'h9);
                if (upd === 1'b1) strobes++;
            end
        end
        checks++;
        if (reqs !== DUP_EXP) begin
            errors++; $display("FAIL dup_reqs got %0d want %0d", reqs, DUP_EXP);
        end
        checks++;
        if (strobes !== DUP_EXP) begin
            errors++;
            $display("FAIL dup_strobes got %0d want %0d", strobes, DUP_EXP);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL dup_ovf got %b want 0", ovf);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_dedup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_miss_refill.md
Name: fetch_miss_refill

Overview:
- Other end of the fetch pipeline's miss/update interface. Consumes the cache-miss requests (tag/index/offset plus miss pulse) raised by the hit/miss stage.
- Reads the missing cacheline from memory over a beat-wise request/response bus and assembles the beats into a full line.
- Returns the assembled line to the tag store and cache memory as a one-cycle update write.
- Sits between the fetch unit and the memory/bus interface.

Parameters:
- offsetSize, 5, byte-offset bits within a cacheline
- indexSize, 8, cacheline index bits
- tagSize, 64-(offsetSize+indexSize), tag bits
- cachelineSizeBits, 2**offsetSize*8, line width in bits (256)
- memBusWidth, 64, memory response data width; must divide cachelineSizeBits
- queueDepth, 4, miss request FIFO entries, power of two

Ports:
- clock_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- missTag_i  in  tagSize  tag of missed fetch
- missIndex_i  in  indexSize  index of missed fetch
- missOffset_i  in  offsetSize  offset of missed fetch
- isCacheMiss_i  in  1  single-cycle miss pulse; no backpressure
- missQueueFull_o  out  1  FIFO full; core must stall fetch
- missOverflow_o  out  1  sticky: a miss arrived while full and was dropped
- memReqValid_o  out  1  memory read request valid
- memReqReady_i  in  1  memory accepts request
- memReqAddr_o  out  64  line-aligned address {tag,index,offset=0}
- memRspValid_i  in  1  response beat valid
- memRspData_i  in  memBusWidth  response beat data
- newTag_o  out  tagSize  update tag
- newIndex_o  out  indexSize  update index
- newOffset_o  out  offsetSize  original miss offset
- newCacheline_o  out  cachelineSizeBits  assembled line
- cacheUpdateEnable_o  out  1  one-cycle update write strobe

Behaviour:
- Reset (reset_i low, async):
  - FIFO empty; FSM in IDLE; beat counter 0.
  - All outputs 0, including missOverflow_o and newCacheline_o.
  - Reset mid-transfer abandons the line; no update strobe is issued.
- FIFO:
  - isCacheMiss_i high and not full -> push {tag,index,offset} at that edge.
  - Push while full -> drop the miss and set missOverflow_o; stays set until reset.
  - Push and pop in the same cycle while full -> pop frees the slot and the push is accepted.
  - missQueueFull_o = count==queueDepth, registered from count.
- FSM, states IDLE, REQ, RECV, WRITE:
  - IDLE: FIFO non-empty -> pop head into the in-flight register and go to REQ.
  - REQ: memReqValid_o=1 and memReqAddr_o = in-flight line address. The address is held stable until memReqReady_i. Handshake -> RECV, beat counter=0.
  - RECV: each memRspValid_i captures memRspData_i into line bits [k*memBusWidth : k*memBusWidth+memBusWidth-1], k = beat counter, then k increments. Capture of beat beatsPerLine-1 -> WRITE. Beats arriving outside RECV are ignored.
  - WRITE: cacheUpdateEnable_o=1 for exactly one cycle with newTag_o/newIndex_o/newOffset_o/newCacheline_o valid, then IDLE. The data outputs hold their values after the strobe.
- Latency:
  - Miss pulse at edge N -> memReqValid_o high from cycle N+2 when the FIFO was empty, the FSM idle and no dedup drop.
  - Last beat at edge M -> cacheUpdateEnable_o high in cycle M+1.
- One outstanding memory request at a time; requests are served in strict FIFO order.
- Widths: beatsPerLine = cachelineSizeBits/memBusWidth (4 by default). The beat counter is clog2(beatsPerLine) bits and wraps to 0 on entry to RECV.

Optional Feature:
- MISS_DEDUP_EN defined:
  - An incoming miss whose {tag,index} matches any valid FIFO entry, or the in-flight line (REQ/RECV/WRITE), is silently discarded.
  - A discarded miss does not set missOverflow_o, even when the FIFO is full.
- MISS_DEDUP_EN undefined: every miss is enqueued, and duplicates cause repeated refills.

Test Plan:
- Reset, then a single miss tag=0x1, index=0x05, offset=0x0C -> memReqAddr_o=0x0000_0000_0000_20A0 (offset bits zeroed) at cycle N+2. Drive 4 beats 0x11..,0x22..,0x33..,0x44.. -> one strobe with newCacheline_o = beats concatenated in order and newOffset_o=0x0C.
- memReqReady_i held low 10 cycles -> memReqValid_o and memReqAddr_o stable throughout; no beats captured; transfer completes after ready.
- 5 distinct misses back-to-back with memory stalled -> missQueueFull_o after 4 pushes; 5th sets missOverflow_o=1; exactly 4 update strobes are issued in push order.
- Full FIFO, push coincident with IDLE pop -> push accepted; missOverflow_o stays 0.
- reset_i asserted after beat 2 of 4 -> all outputs 0 immediately; no cacheUpdateEnable_o afterward; a new miss after release refills normally.
- With MISS_DEDUP_EN: two misses to the same line 1 cycle apart -> one memory request and one strobe. Without MISS_DEDUP_EN -> two requests and two strobes.
